ssd_reader: RTL and testbench
=============================

# ssd_reader

Seven-segment display reader: watches a scanned, active-low 4-digit seven-segment bus (segment lines plus per-digit anode strobes) and recovers the BCD value shown on each digit. It is the decode direction of the team's BCD-to-segment driver. It sits on the bench/monitor side of the multiplier display path, so the displayed product can be checked as numbers rather than segment patterns.

## Interface
Parameters:
- SETTLE, default 4: consecutive stable cycles required before a digit is captured. Legal range 1..255.

Ports:
- clk  in  1  clock. One clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- an  in  4  digit strobes, active-low. an[i]=0 selects digit i.
- Seg  in  7  segment lines, active-low. Bit 0 = A, 1 = B, 2 = C, 3 = D, 4 = E, 5 = F, 6 = G.
- bcd  out  16  recovered digits; digit i is held in bcd[4i+3:4i].
- dig_valid  out  4  sticky per digit: set once digit i has been captured at least once since reset.
- dig_err  out  4  per digit: the last capture of digit i was an illegal pattern.
- frame_done  out  1  one-cycle pulse when all four digits have been captured since the previous pulse or since reset.

## Operation
- Legal strobe: `an` has exactly one bit low. Zero or multiple bits low means no digit is selected. This covers blanking and ghosting overlap.
- Input sample registers `s_an` and `s_Seg` load every cycle.
- Stability counter `cnt`, 8 bits:
  - If the current inputs equal the sample registers and the strobe is legal, `cnt` increments, saturating at SETTLE.
  - Otherwise `cnt` loads 1 when the strobe is legal, or 0 when it is not.
- FSM states:
  - WAIT: no legal strobe, or `cnt` < SETTLE.
  - CAPTURE: entered for exactly one cycle when `cnt` reaches SETTLE.
  - HOLD: held until `an` or `Seg` changes or the strobe becomes illegal, then return to WAIT.
  - One dwell produces exactly one capture, even if the inputs are held indefinitely.
- Capture decode of `Seg`, inverse of the driver table:
  - 7'b1000000 → 0
  - 7'b1111001 → 1
  - 7'b0100100 → 2
  - 7'b0110000 → 3
  - 7'b0011001 → 4
  - 7'b0010010 → 5
  - 7'b0000010 → 6
  - 7'b1111000 → 7
  - 7'b0000000 → 8
  - 7'b0010000 → 9
  - 7'b1111111 (blank) → 4'hF, dig_err=0
  - Any other pattern → 4'hF, dig_err=1
- Each capture of digit i:
  - writes its bcd nibble and dig_err[i];
  - sets dig_valid[i];
  - sets bit i of the internal mask `seen[3:0]`.
- Recapturing a digit already in `seen` overwrites its nibble and error bit. `seen` is unchanged.
- When the capture makes `seen` equal to 4'b1111:
  - frame_done pulses in the same cycle that the capture's outputs update;
  - `seen` clears to 4'b0000 in that cycle.

## Timing
- Reset values: bcd=16'h0000, dig_valid=4'h0, dig_err=4'h0, frame_done=0, cnt=0, seen=0, FSM=WAIT, sample registers=all ones.
- Latency: with `an` and `Seg` constant and legal from before rising edge 1, bcd, dig_valid and dig_err reflect the capture after edge SETTLE+1. For SETTLE=4 that is edge 5.
- frame_done is high for exactly one cycle, aligned with the output update of the completing capture.
- A change of `an` or `Seg` during a dwell restarts the count; the partial dwell produces no capture.
- A dwell shorter than SETTLE cycles is ignored entirely.
- Reset asserted mid-dwell or mid-frame:
  - all state returns to its reset values on that edge;
  - after reset deasserts, counting starts fresh;
  - inputs held across reset still need SETTLE cycles following the first sample after reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Basic capture:** SETTLE=4; an=4'b1110, Seg=7'b0110000 held 10 cycles → bcd[3:0]=3 after edge 5; dig_valid=4'b0001, dig_err=0; exactly one capture (bcd stable, no frame_done).
- **Full frame:** scan digits 0..3 with 1, 2, 8, 9, each held 6 cycles → bcd=16'h9821; frame_done pulses once, on the cycle digit 3 updates; repeating the scan gives a second single pulse.
- **Short dwell and glitch:**
  - an=4'b1101 with "7" for 3 cycles → no update;
  - "7" for 2 cycles, then one cycle of 7'b0000000, then "7" for 4 cycles → capture only after the final 4 stable cycles, bcd[7:4]=7.
- **Illegal strobes:** an=4'b1100 or an=4'b1111 with any Seg held 20 cycles → no capture; cnt stays 0; outputs unchanged.
- **Error and blank:**
  - Seg=7'b1010101 on digit 2 → bcd[11:8]=F, dig_err[2]=1;
  - then Seg=7'b1111111 on digit 2 → bcd[11:8]=F, dig_err[2]=0, dig_valid[2]=1.
- **Reset mid-operation:** capture digits 0..2, then pulse rst for 1 cycle with digit 3 strobed → all outputs return to reset values; digit 3 is captured SETTLE+1 edges after rst falls; no frame_done, since seen=4'b1000.

Source files
------------

// File: rtl/ssd_reader.sv
// Seven-segment bus reader: recovers BCD digits from a scanned, active-low
// 4-digit display once each digit has dwelt on the bus for SETTLE cycles.
module ssd_reader #(
    parameter int SETTLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  Seg,
    output logic [15:0] bcd,
    output logic [3:0]  dig_valid,
    output logic [3:0]  dig_err,
    output logic        frame_done
);

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

    localparam logic [7:0] SETTLE_CNT = 8'(SETTLE);

    // A legal strobe has exactly one anode pulled low.
    function automatic logic strobe_legal(input logic [3:0] a);
        return (a == 4'b1110) || (a == 4'b1101) ||
               (a == 4'b1011) || (a == 4'b0111);
    endfunction

    function automatic logic [1:0] strobe_index(input logic [3:0] a);
        logic [1:0] idx;
        case (a)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    // Returns {err, nibble}; blank decodes to F without flagging an error.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] res;
        case (s)
            7'b1000000: res = 5'h00;
            7'b1111001: res = 5'h01;
            7'b0100100: res = 5'h02;
            7'b0110000: res = 5'h03;
            7'b0011001: res = 5'h04;
            7'b0010010: res = 5'h05;
            7'b0000010: res = 5'h06;
            7'b1111000: res = 5'h07;
            7'b0000000: res = 5'h08;
            7'b0010000: res = 5'h09;
            7'b1111111: res = 5'h0F;
            default:    res = 5'h1F;
        endcase
        return res;
    endfunction

    logic [3:0] r_s_an;
    logic [6:0] r_s_seg;
    logic [7:0] r_cnt;
    logic [3:0] r_seen;
    state_t     r_state;

    logic       w_legal;
    logic       w_same;
    logic [7:0] w_cnt_next;
    logic [1:0] w_idx;
    logic [4:0] w_decode;
    logic [3:0] w_seen_next;

    assign w_legal     = strobe_legal(an);
    assign w_same      = w_legal && (an == r_s_an) && (Seg == r_s_seg);
    assign w_idx       = strobe_index(r_s_an);
    assign w_decode    = seg_decode(r_s_seg);
    assign w_seen_next = r_seen | (4'b0001 << w_idx);

    // NOTE: the default assignment first guarantees no latch is inferred.
    always_comb begin
        w_cnt_next = 8'd0;
        if (w_same) begin
            w_cnt_next = (r_cnt >= SETTLE_CNT) ? r_cnt : r_cnt + 8'd1;
        end else if (w_legal) begin
            w_cnt_next = 8'd1;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every register
    // sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_an     <= 4'hF;
            r_s_seg    <= 7'h7F;
            r_cnt      <= 8'd0;
            r_seen     <= 4'h0;
            r_state    <= ST_WAIT;
            bcd        <= 16'h0000;
            dig_valid  <= 4'h0;
            dig_err    <= 4'h0;
            frame_done <= 1'b0;
        end else begin
            r_s_an     <= an;
            r_s_seg    <= Seg;
            r_cnt      <= w_cnt_next;
            frame_done <= 1'b0;

            // The sample registers still hold the dwell that completed.
            if (r_state == ST_CAPTURE) begin
                bcd[{w_idx, 2'b00} +: 4] <= w_decode[3:0];
                dig_err[w_idx]           <= w_decode[4];
                dig_valid[w_idx]         <= 1'b1;
                if (w_seen_next == 4'hF) begin
                    frame_done <= 1'b1;
                    r_seen     <= 4'h0;
                end else begin
                    r_seen <= w_seen_next;
                end
            end

            if (!w_same) begin
                r_state <= (w_legal && (w_cnt_next == SETTLE_CNT)) ? ST_CAPTURE : ST_WAIT;
            end else begin
                case (r_state)
                    ST_WAIT:    r_state <= (w_cnt_next == SETTLE_CNT) ? ST_CAPTURE : ST_WAIT;
                    ST_CAPTURE: r_state <= ST_HOLD;
                    ST_HOLD:    r_state <= ST_HOLD;
                    default:    r_state <= ST_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd_reader.sv
// Bench for ssd_reader: directed scenarios plus random dwells compared
// against a dwell-length reference model.
module tb_ssd_reader;

    localparam int SETTLE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [15:0] bcd;
    logic [3:0]  dig_valid;
    logic [3:0]  dig_err;
    logic        frame_done;

    int errors = 0;
    int checks = 0;
    int frames = 0;

    // Reference model state
    logic [15:0] m_bcd;
    logic [3:0]  m_valid;
    logic [3:0]  m_err;
    logic [3:0]  m_seen;
    logic        m_frame;
    int          m_run;
    logic        m_prev_ok;
    logic [3:0]  m_prev_an;
    logic [6:0]  m_prev_seg;
    logic        m_pend;
    logic [3:0]  m_pend_an;
    logic [6:0]  m_pend_seg;

    ssd_reader #(.SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .Seg        (seg),
        .bcd        (bcd),
        .dig_valid  (dig_valid),
        .dig_err    (dig_err),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            default: return 7'b0010000;
        endcase
    endfunction

    function automatic logic [3:0] an_for(input int d);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        return a;
    endfunction

    // Index of the single low anode, or -1 when the strobe is not legal.
    function automatic int strobe_digit(input logic [3:0] a);
        int n;
        int idx;
        n = 0;
        idx = -1;
        for (int i = 0; i < 4; i++) begin
            if (!a[i]) begin
                n++;
                idx = i;
            end
        end
        return (n == 1) ? idx : -1;
    endfunction

    // A capture becomes visible one edge after a dwell reaches SETTLE edges.
    task automatic model_edge(input logic [3:0] a, input logic [6:0] s, input logic r);
        int   d;
        logic [3:0] nib;
        logic err;
        if (r) begin
            m_bcd = 16'h0; m_valid = 4'h0; m_err = 4'h0; m_seen = 4'h0;
            m_frame = 1'b0; m_run = 0; m_prev_ok = 1'b0; m_pend = 1'b0;
            m_prev_an = 4'hF; m_prev_seg = 7'h7F; m_pend_an = 4'hF; m_pend_seg = 7'h7F;
        end else begin
            m_frame = 1'b0;
            if (m_pend) begin
                d = strobe_digit(m_pend_an);
                nib = 4'hF;
                err = (m_pend_seg != 7'h7F);
                for (int v = 0; v < 10; v++) begin
                    if (m_pend_seg == seg_of(v)) begin
                        nib = 4'(v);
                        err = 1'b0;
                    end
                end
                m_bcd[d*4 +: 4] = nib;
                m_err[d] = err;
                m_valid[d] = 1'b1;
                m_seen[d] = 1'b1;
                if (m_seen == 4'hF) begin
                    m_frame = 1'b1;
                    m_seen = 4'h0;
                end
            end
            m_pend = 1'b0;
            if (strobe_digit(a) >= 0) begin
                if (m_prev_ok && a == m_prev_an && s == m_prev_seg)
                    m_run = (m_run < 1000) ? m_run + 1 : m_run;
                else
                    m_run = 1;
                m_prev_ok = 1'b1;
            end else begin
                m_run = 0;
                m_prev_ok = 1'b0;
            end
            m_prev_an = a;
            m_prev_seg = s;
            if (m_run == SETTLE) begin
                m_pend = 1'b1;
                m_pend_an = a;
                m_pend_seg = s;
            end
        end
    endtask

    // Drive inputs, clock one edge, then return at the falling edge.
    task automatic tick(input logic [3:0] a, input logic [6:0] s, input logic r);
        an = a;
        seg = s;
        rst = r;
        @(posedge clk);
        model_edge(a, s, r);
        @(negedge clk);
        if (frame_done === 1'b1) frames++;
    endtask

    task automatic do_reset();
        tick(4'hF, 7'h7F, 1'b1);
        frames = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd); end
        checks++;
        if (dig_valid !== 4'h0 || dig_err !== 4'h0) begin
            errors++; $display("FAIL reset_flags: valid=%b err=%b expected 0000/0000", dig_valid, dig_err);
        end
        checks++;
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b expected 0", frame_done); end
    endtask

    task automatic test_basic_capture();
        do_reset();
        repeat (SETTLE) tick(4'b1110, seg_of(3), 1'b0);
        checks++;
        if (bcd !== 16'h0000 || dig_valid !== 4'h0) begin
            errors++; $display("FAIL basic_early: bcd=%h valid=%b expected 0000/0000", bcd, dig_valid);
        end
        tick(4'b1110, seg_of(3), 1'b0);
        checks++;
        if (bcd !== 16'h0003 || dig_valid !== 4'b0001 || dig_err !== 4'h0) begin
            errors++; $display("FAIL basic_capture: bcd=%h valid=%b err=%b expected 0003/0001/0000", bcd, dig_valid, dig_err);
        end
        repeat (5) tick(4'b1110, seg_of(3), 1'b0);
        checks++;
        if (bcd !== 16'h0003 || frames !== 0) begin
            errors++; $display("FAIL basic_hold: bcd=%h frames=%0d expected 0003/0", bcd, frames);
        end
    endtask

    task automatic test_full_frame();
        int vals[4] = '{1, 2, 8, 9};
        logic aligned;
        do_reset();
        for (int pass = 1; pass <= 2; pass++) begin
            aligned = 1'b0;
            for (int d = 0; d < 4; d++) begin
                for (int c = 0; c < 6; c++) begin
                    tick(an_for(d), seg_of(vals[d]), 1'b0);
                    if (d == 3 && c == SETTLE && frame_done === 1'b1 && bcd[15:12] === 4'h9)
                        aligned = 1'b1;
                end
            end
            checks++;
            if (!aligned) begin errors++; $display("FAIL frame_align: pass %0d pulse not on digit 3 update", pass); end
            checks++;
            if (frames !== pass) begin errors++; $display("FAIL frame_count: got %0d expected %0d", frames, pass); end
        end
        checks++;
        if (bcd !== 16'h9821 || dig_valid !== 4'hF) begin
            errors++; $display("FAIL frame_value: bcd=%h valid=%b expected 9821/1111", bcd, dig_valid);
        end
    endtask

    task automatic test_short_dwell();
        do_reset();
        repeat (3) tick(4'b1101, seg_of(7), 1'b0);
        tick(4'hF, 7'h7F, 1'b0);
        checks++;
        if (bcd !== 16'h0000 || dig_valid !== 4'h0) begin
            errors++; $display("FAIL short_dwell: bcd=%h valid=%b expected 0000/0000", bcd, dig_valid);
        end
        repeat (2) tick(4'b1101, seg_of(7), 1'b0);
        tick(4'b1101, 7'b0000000, 1'b0);
        repeat (4) tick(4'b1101, seg_of(7), 1'b0);
        checks++;
        if (bcd !== 16'h0000 || dig_valid !== 4'h0) begin
            errors++; $display("FAIL glitch_early: bcd=%h valid=%b expected 0000/0000", bcd, dig_valid);
        end
        tick(4'b1101, seg_of(7), 1'b0);
        checks++;
        if (bcd !== 16'h0070 || dig_valid !== 4'b0010) begin
            errors++; $display("FAIL glitch_capture: bcd=%h valid=%b expected 0070/0010", bcd, dig_valid);
        end
    endtask

    task automatic test_illegal_strobe();
        logic [3:0] pats[2] = '{4'b1100, 4'b1111};
        logic cnt_ok;
        do_reset();
        repeat (6) tick(4'b1110, seg_of(5), 1'b0);
        for (int p = 0; p < 2; p++) begin
            cnt_ok = 1'b1;
            for (int c = 0; c < 20; c++) begin
                tick(pats[p], 7'($urandom), 1'b0);
                if (dut.r_cnt !== 8'd0) cnt_ok = 1'b0;
            end
            checks++;
            if (!cnt_ok) begin errors++; $display("FAIL illegal_cnt: an=%b counter left zero", pats[p]); end
            checks++;
            if (bcd !== 16'h0005 || dig_valid !== 4'b0001 || dig_err !== 4'h0 || frames !== 0) begin
                errors++; $display("FAIL illegal_hold: an=%b bcd=%h valid=%b err=%b expected 0005/0001/0000", pats[p], bcd, dig_valid, dig_err);
            end
        end
    endtask

    task automatic test_error_blank();
        do_reset();
        repeat (5) tick(4'b1011, 7'b1010101, 1'b0);
        checks++;
        if (bcd[11:8] !== 4'hF || dig_err !== 4'b0100 || dig_valid !== 4'b0100) begin
            errors++; $display("FAIL error_pattern: nib=%h err=%b valid=%b expected F/0100/0100", bcd[11:8], dig_err, dig_valid);
        end
        repeat (5) tick(4'b1011, 7'b1111111, 1'b0);
        checks++;
        if (bcd[11:8] !== 4'hF || dig_err !== 4'b0000 || dig_valid !== 4'b0100) begin
            errors++; $display("FAIL blank_pattern: nib=%h err=%b valid=%b expected F/0000/0100", bcd[11:8], dig_err, dig_valid);
        end
    endtask

    task automatic test_reset_mid();
        int vals[3] = '{4, 5, 6};
        do_reset();
        for (int d = 0; d < 3; d++)
            repeat (6) tick(an_for(d), seg_of(vals[d]), 1'b0);
        checks++;
        if (bcd !== 16'h0654 || dig_valid !== 4'b0111) begin
            errors++; $display("FAIL midreset_pre: bcd=%h valid=%b expected 0654/0111", bcd, dig_valid);
        end
        repeat (2) tick(4'b0111, seg_of(7), 1'b0);
        tick(4'b0111, seg_of(7), 1'b1);
        checks++;
        if (bcd !== 16'h0000 || dig_valid !== 4'h0 || dig_err !== 4'h0 || frame_done !== 1'b0) begin
            errors++; $display("FAIL midreset_clear: bcd=%h valid=%b err=%b expected all zero", bcd, dig_valid, dig_err);
        end
        repeat (SETTLE) tick(4'b0111, seg_of(7), 1'b0);
        checks++;
        if (bcd !== 16'h0000) begin errors++; $display("FAIL midreset_early: bcd=%h expected 0000", bcd); end
        tick(4'b0111, seg_of(7), 1'b0);
        repeat (3) tick(4'b0111, seg_of(7), 1'b0);
        checks++;
        if (bcd !== 16'h7000 || dig_valid !== 4'b1000 || frames !== 0) begin
            errors++; $display("FAIL midreset_capture: bcd=%h valid=%b frames=%0d expected 7000/1000/0", bcd, dig_valid, frames);
        end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [6:0] s;
        logic       r;
        int kind;
        int len;
        int bad;
        do_reset();
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            kind = $urandom_range(0, 19);
            r = (kind == 0);
            if (kind < 3) begin
                do a = 4'($urandom); while (strobe_digit(a) >= 0);
            end else begin
                a = an_for($urandom_range(0, 3));
            end
            kind = $urandom_range(0, 19);
            if (kind < 14)      s = seg_of($urandom_range(0, 9));
            else if (kind < 17) s = 7'h7F;
            else                s = 7'($urandom);
            len = r ? 1 : $urandom_range(1, 2 * SETTLE);
            for (int c = 0; c < len; c++) begin
                tick(a, s, r);
                checks++;
                if ({bcd, dig_valid, dig_err, frame_done} !== {m_bcd, m_valid, m_err, m_frame}) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL random_model: bcd=%h valid=%b err=%b frame=%b expected %h/%b/%b/%b",
                                 bcd, dig_valid, dig_err, frame_done, m_bcd, m_valid, m_err, m_frame);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        an = 4'hF;
        seg = 7'h7F;
        @(negedge clk);
        test_reset();
        test_basic_capture();
        test_full_frame();
        test_short_dwell();
        test_illegal_strobe();
        test_error_blank();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
